// File: rtl/mda_pkg.sv
// Shared constants, control codes, FSM states and cell layout for the MDA text writer.
// Address arithmetic is fixed at 80x25 cells (11-bit addresses, max 1999).
package mda_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
    localparam logic [10:0] COLS_A     = 11'(COLS);
    localparam logic [10:0] SCROLL_LEN = 11'(CELLS - COLS);
    localparam logic [10:0] LAST_CELL  = 11'(CELLS - 1);

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PUT    = 2'd1,
        ST_SCROLL = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } cell_t;

    function automatic logic is_printable(input logic [7:0] c);
        return !((c == CC_BS) || (c == CC_LF) || (c == CC_FF) || (c == CC_CR));
    endfunction

endpackage

// File: rtl/mda_text_writer_if.sv
// Character stream in, VRAM port and cursor/status out for the MDA text writer.
// master = stream source / VRAM owner side, slave = the writer itself.
interface mda_text_writer_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [7:0]  in_attr;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;
    logic [10:0] ram_waddr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [10:0] ram_raddr;
    logic        ram_re;
    logic [15:0] ram_rdata;

    modport master (
        output in_valid, in_char, in_attr, ram_rdata,
        input  in_ready, cursor_col, cursor_row, busy,
        input  ram_waddr, ram_wdata, ram_we, ram_raddr, ram_re
    );

    modport slave (
        input  in_valid, in_char, in_attr, ram_rdata,
        output in_ready, cursor_col, cursor_row, busy,
        output ram_waddr, ram_wdata, ram_we, ram_raddr, ram_re
    );

endinterface

// File: rtl/mda_cell_addr.sv
// Cell address row*80+col as shift-and-add; combinational, no backpressure.
module mda_cell_addr (
    input  logic [4:0]  row,
    input  logic [6:0]  col,
    output logic [10:0] addr
);

    assign addr = {row, 6'b0} + {2'b0, row, 4'b0} + {4'b0, col};

endmodule

// File: rtl/mda_text_writer.sv
// Cursor-tracking writer into MDA VRAM: one char per accept, acted on the next cycle.
// in_ready only in IDLE, so the stream is held off through PUT, SCROLL and CLEAR.
module mda_text_writer
    import mda_pkg::*;
#(
    parameter logic [7:0] FILL_ATTR = 8'h07,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    mda_text_writer_if.slave  bus
);

    localparam cell_t FILL_CELL = '{attr: FILL_ATTR, chr: FILL_CHAR};

    state_t      state;
    logic [6:0]  col;
    logic [4:0]  row;
    logic [7:0]  chr_q;
    cell_t       wdata_q;
    logic        we_q;
    logic        re_q;
    logic [10:0] waddr_q;
    logic [10:0] raddr_q;
    logic [10:0] cnt;
    logic        clear_home;
    logic [10:0] cur_addr;

    logic is_pr;
    logic wrap;
    logic do_lf;

    mda_cell_addr u_cell_addr (
        .row  (row),
        .col  (col),
        .addr (cur_addr)
    );

    assign is_pr = is_printable(chr_q);
    assign wrap  = is_pr && (col == LAST_COL);
    assign do_lf = (chr_q == CC_LF) || wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            chr_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            cnt        <= '0;
            clear_home <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        chr_q   <= bus.in_char;
                        wdata_q <= '{attr: bus.in_attr, chr: bus.in_char};
                        we_q    <= is_printable(bus.in_char);
                        waddr_q <= cur_addr;
                        state   <= ST_PUT;
                    end
                end

                ST_PUT: begin
                    we_q <= 1'b0;
                    if (chr_q == CC_FF) begin
                        we_q       <= 1'b1;
                        waddr_q    <= '0;
                        wdata_q    <= FILL_CELL;
                        cnt        <= '0;
                        clear_home <= 1'b1;
                        state      <= ST_CLEAR;
                    end else begin
                        if ((chr_q == CC_CR) || wrap) begin
                            col <= '0;
                        end else if ((chr_q == CC_BS) && (col != '0)) begin
                            col <= col - 7'd1;
                        end else if (is_pr) begin
                            col <= col + 7'd1;
                        end
                        // LF on the bottom row keeps the row and shifts the screen up instead.
                        if (do_lf && (row == LAST_ROW)) begin
                            re_q    <= 1'b1;
                            raddr_q <= COLS_A;
                            cnt     <= '0;
                            state   <= ST_SCROLL;
                        end else begin
                            if (do_lf) begin
                                row <= row + 5'd1;
                            end
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_SCROLL: begin
                    if (cnt == SCROLL_LEN) begin
                        re_q       <= 1'b0;
                        raddr_q    <= '0;
                        we_q       <= 1'b1;
                        waddr_q    <= SCROLL_LEN;
                        wdata_q    <= FILL_CELL;
                        cnt        <= SCROLL_LEN;
                        clear_home <= 1'b0;
                        state      <= ST_CLEAR;
                    end else begin
                        // Write trails the read by one cell, matching the 1-cycle read latency.
                        we_q    <= 1'b1;
                        waddr_q <= cnt;
                        cnt     <= cnt + 11'd1;
                        if (cnt == SCROLL_LEN - 11'd1) begin
                            re_q    <= 1'b0;
                            raddr_q <= '0;
                        end else begin
                            raddr_q <= raddr_q + 11'd1;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (cnt == LAST_CELL) begin
                        we_q    <= 1'b0;
                        waddr_q <= '0;
                        state   <= ST_IDLE;
                        if (clear_home) begin
                            col <= '0;
                            row <= '0;
                        end
                    end else begin
                        cnt     <= cnt + 11'd1;
                        waddr_q <= cnt + 11'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.busy       = (state == ST_SCROLL) || (state == ST_CLEAR);
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;
    assign bus.ram_we     = we_q;
    assign bus.ram_waddr  = waddr_q;
    assign bus.ram_re     = re_q;
    assign bus.ram_raddr  = raddr_q;
    // Scroll copies pass the read data straight through to the write port.
    assign bus.ram_wdata  = (state == ST_SCROLL) ? bus.ram_rdata : wdata_q;

endmodule

// File: tb/tb_mda_text_writer.sv
// Bench for mda_text_writer: vector table, hand sequences for scroll/clear/reset,
// and a random character stream against a screen-level reference model.
module tb_mda_text_writer;

    logic clk;
    logic rst_n;

    mda_text_writer_if ifc ();

    mda_text_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // VRAM behaviour and running counters of bus activity
    logic [15:0] vram [0:1999];
    int wr_total = 0;
    int wr_fill  = 0;
    int viol     = 0;

    always @(posedge clk) begin
        if (ifc.ram_we) begin
            if (ifc.ram_waddr < 11'd2000) vram[ifc.ram_waddr] = ifc.ram_wdata;
            wr_total++;
            if (ifc.ram_wdata == 16'h0720) wr_fill++;
        end
        if (ifc.ram_re && (ifc.ram_raddr < 11'd2000)) ifc.ram_rdata <= vram[ifc.ram_raddr];
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (ifc.ram_we && (ifc.ram_waddr > 11'd1999)) viol++;
            if (ifc.ram_re && (ifc.ram_raddr > 11'd1999)) viol++;
            if (ifc.ram_we && ifc.ram_re && (ifc.ram_waddr == ifc.ram_raddr)) viol++;
            if (ifc.in_valid && ifc.in_ready && ifc.busy) viol++;
        end
    end

    // Screen-level reference model
    logic [15:0] mv [0:1999];
    int mcol = 0;
    int mrow = 0;

    function automatic void m_lf();
        if (mrow < 24) mrow++;
        else begin
            for (int i = 0; i < 1920; i++) mv[i] = mv[i + 80];
            for (int i = 1920; i < 2000; i++) mv[i] = 16'h0720;
        end
    endfunction

    function automatic void m_apply(input logic [7:0] c, input logic [7:0] a);
        case (c)
            8'h0D: mcol = 0;
            8'h08: if (mcol > 0) mcol--;
            8'h0A: m_lf();
            8'h0C: begin
                for (int i = 0; i < 2000; i++) mv[i] = 16'h0720;
                mcol = 0;
                mrow = 0;
            end
            default: begin
                mv[mrow * 80 + mcol] = {a, c};
                if (mcol < 79) mcol++;
                else begin
                    mcol = 0;
                    m_lf();
                end
            end
        endcase
    endfunction

    function automatic logic is_ctrl(input logic [7:0] c);
        return (c == 8'h08) || (c == 8'h0A) || (c == 8'h0C) || (c == 8'h0D);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(output int busy_cycles);
        int t;
        t = 0;
        busy_cycles = 0;
        while (!(ifc.in_ready && !ifc.busy) && (t < 5000)) begin
            if (ifc.busy) busy_cycles++;
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Present one character, return what the write port shows in the cycle after accept.
    task automatic send(input logic [7:0] c, input logic [7:0] a,
                        output logic we1, output logic [10:0] ad1,
                        output logic [15:0] d1, output logic rdy1, output int bc);
        int t;
        t = 0;
        ifc.in_char  = c;
        ifc.in_attr  = a;
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && (t < 5000)) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 5000) check("ready_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        we1  = ifc.ram_we;
        ad1  = ifc.ram_waddr;
        d1   = ifc.ram_wdata;
        rdy1 = ifc.in_ready;
        wait_idle(bc);
    endtask

    task automatic send_model(input logic [7:0] c, input logic [7:0] a);
        logic we1, r1;
        logic [10:0] ad;
        logic [15:0] d;
        int bc, exp_ad;
        logic exp_we;
        exp_we = !is_ctrl(c);
        exp_ad = mrow * 80 + mcol;
        send(c, a, we1, ad, d, r1, bc);
        check("m_we", 32'(we1), 32'(exp_we));
        if (exp_we) begin
            check("m_addr", 32'(ad), 32'(exp_ad));
            check("m_data", 32'(d), 32'({a, c}));
        end
        m_apply(c, a);
        check("m_col", 32'(ifc.cursor_col), 32'(mcol));
        check("m_row", 32'(ifc.cursor_row), 32'(mrow));
    endtask

    task automatic compare_vram(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 2000; i++) if (vram[i] !== mv[i]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        ifc.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mcol = 0;
        mrow = 0;
    endtask

    typedef struct {
        logic [7:0]  c;
        logic [7:0]  a;
        logic        we;
        logic [10:0] addr;
        logic [15:0] data;
        logic [6:0]  col;
        logic [4:0]  row;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic we1, r1;
        logic [10:0] ad;
        logic [15:0] d;
        int bc, t, w0, f0;
        logic [7:0] c, a;

        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_char  = '0;
        ifc.in_attr  = '0;

        tbl[0]  = '{8'h41, 8'h07, 1'b1, 11'd0,   16'h0741, 7'd1, 5'd0};
        tbl[1]  = '{8'h42, 8'h1F, 1'b1, 11'd1,   16'h1F42, 7'd2, 5'd0};
        tbl[2]  = '{8'h0D, 8'h00, 1'b0, 11'd0,   16'h0000, 7'd0, 5'd0};
        tbl[3]  = '{8'h08, 8'h00, 1'b0, 11'd0,   16'h0000, 7'd0, 5'd0};
        tbl[4]  = '{8'h0A, 8'h00, 1'b0, 11'd0,   16'h0000, 7'd0, 5'd1};
        tbl[5]  = '{8'h78, 8'h70, 1'b1, 11'd80,  16'h7078, 7'd1, 5'd1};
        tbl[6]  = '{8'h08, 8'h00, 1'b0, 11'd0,   16'h0000, 7'd0, 5'd1};
        tbl[7]  = '{8'h79, 8'h07, 1'b1, 11'd80,  16'h0779, 7'd1, 5'd1};
        tbl[8]  = '{8'h0A, 8'h00, 1'b0, 11'd0,   16'h0000, 7'd1, 5'd2};
        tbl[9]  = '{8'h7A, 8'h07, 1'b1, 11'd161, 16'h077A, 7'd2, 5'd2};
        tbl[10] = '{8'h0D, 8'h00, 1'b0, 11'd0,   16'h0000, 7'd0, 5'd2};
        tbl[11] = '{8'h08, 8'h00, 1'b0, 11'd0,   16'h0000, 7'd0, 5'd2};

        // Reset state
        do_reset();
        check("rst_col",   32'(ifc.cursor_col), 32'd0);
        check("rst_row",   32'(ifc.cursor_row), 32'd0);
        check("rst_ready", 32'(ifc.in_ready),   32'd1);
        check("rst_busy",  32'(ifc.busy),       32'd0);
        check("rst_we",    32'(ifc.ram_we),     32'd0);
        check("rst_re",    32'(ifc.ram_re),     32'd0);
        check("rst_waddr", 32'(ifc.ram_waddr),  32'd0);
        check("rst_wdata", 32'(ifc.ram_wdata),  32'd0);

        // Vector table from (0,0)
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].c, tbl[i].a, we1, ad, d, r1, bc);
            check("tbl_we",    32'(we1), 32'(tbl[i].we));
            check("tbl_ready", 32'(r1),  32'd0);
            if (tbl[i].we) begin
                check("tbl_addr", 32'(ad), 32'(tbl[i].addr));
                check("tbl_data", 32'(d),  32'(tbl[i].data));
            end
            check("tbl_col", 32'(ifc.cursor_col), 32'(tbl[i].col));
            check("tbl_row", 32'(ifc.cursor_row), 32'(tbl[i].row));
        end

        // Cursor (5,3) then CR, BS at column 0, LF
        send(8'h0A, 8'h00, we1, ad, d, r1, bc);
        for (int i = 0; i < 5; i++) send(8'h61, 8'h07, we1, ad, d, r1, bc);
        check("s3_col5", 32'(ifc.cursor_col), 32'd5);
        check("s3_row3", 32'(ifc.cursor_row), 32'd3);
        send(8'h0D, 8'h00, we1, ad, d, r1, bc);
        check("s3_cr_col", 32'(ifc.cursor_col), 32'd0);
        check("s3_cr_we",  32'(we1), 32'd0);
        send(8'h08, 8'h00, we1, ad, d, r1, bc);
        check("s3_bs_col", 32'(ifc.cursor_col), 32'd0);
        check("s3_bs_we",  32'(we1), 32'd0);
        send(8'h0A, 8'h00, we1, ad, d, r1, bc);
        check("s3_lf_col", 32'(ifc.cursor_col), 32'd0);
        check("s3_lf_row", 32'(ifc.cursor_row), 32'd4);

        // A full row of printables wraps to (0,1)
        do_reset();
        for (int i = 0; i < 80; i++) begin
            c = 8'(33 + i);
            send(c, 8'h07, we1, ad, d, r1, bc);
            check("row_we",   32'(we1), 32'd1);
            check("row_addr", 32'(ad),  32'(i));
            check("row_data", 32'(d),   32'({8'h07, c}));
        end
        check("row_col", 32'(ifc.cursor_col), 32'd0);
        check("row_row", 32'(ifc.cursor_row), 32'd1);

        // Scroll from a preloaded screen
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            vram[i] = 16'(i);
            mv[i]   = 16'(i);
        end
        for (int i = 0; i < 24; i++) send_model(8'h0A, 8'h00);
        send_model(8'h5A, 8'h07);
        send(8'h0A, 8'h00, we1, ad, d, r1, bc);
        m_apply(8'h0A, 8'h00);
        check("scr_busy_cycles", 32'(bc), 32'd2001);
        check("scr_col", 32'(ifc.cursor_col), 32'd1);
        check("scr_row", 32'(ifc.cursor_row), 32'd24);
        check("scr_cell0",    32'(vram[0]),    32'd80);
        check("scr_cell1000", 32'(vram[1000]), 32'd1080);
        check("scr_cell1840", 32'(vram[1840]), 32'h075A);
        check("scr_cell1919", 32'(vram[1919]), 32'd1999);
        check("scr_cell1920", 32'(vram[1920]), 32'h0720);
        check("scr_cell1999", 32'(vram[1999]), 32'h0720);
        compare_vram("scr_vram");

        // FF with the next character held valid throughout the clear
        w0 = wr_total;
        f0 = wr_fill;
        ifc.in_char  = 8'h0C;
        ifc.in_attr  = 8'h00;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_char = 8'h51;
        ifc.in_attr = 8'h07;
        t = 0;
        while (!ifc.in_ready && (t < 5000)) begin
            @(posedge clk); #1;
            t++;
        end
        check("ff_wait_cycles", 32'(t), 32'd2001);
        check("ff_writes", 32'(wr_total - w0), 32'd2000);
        check("ff_fills",  32'(wr_fill - f0),  32'd2000);
        check("ff_col", 32'(ifc.cursor_col), 32'd0);
        check("ff_row", 32'(ifc.cursor_row), 32'd0);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        check("ffq_we",   32'(ifc.ram_we),    32'd1);
        check("ffq_addr", 32'(ifc.ram_waddr), 32'd0);
        check("ffq_data", 32'(ifc.ram_wdata), 32'h0751);
        wait_idle(bc);
        m_apply(8'h0C, 8'h00);
        m_apply(8'h51, 8'h07);
        check("ffq_col", 32'(ifc.cursor_col), 32'(mcol));
        compare_vram("ff_vram");

        // Random stream against the model
        for (int n = 0; n < 200; n++) begin
            t = int'($urandom_range(0, 99));
            if (t < 12)      c = 8'h0A;
            else if (t < 16) c = 8'h0D;
            else if (t < 21) c = 8'h08;
            else if (t < 23) c = 8'h0C;
            else begin
                c = 8'($urandom_range(0, 255));
                while (is_ctrl(c)) c = 8'($urandom_range(0, 255));
            end
            a = 8'($urandom_range(0, 255));
            send_model(c, a);
        end
        compare_vram("rnd_vram");

        // Reset in the middle of a scroll
        do_reset();
        for (int i = 0; i < 24; i++) send(8'h0A, 8'h00, we1, ad, d, r1, bc);
        ifc.in_char  = 8'h0A;
        ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (501) begin
            @(posedge clk); #1;
        end
        check("mid_re",    32'(ifc.ram_re),    32'd1);
        check("mid_raddr", 32'(ifc.ram_raddr), 32'd580);
        check("mid_we",    32'(ifc.ram_we),    32'd1);
        check("mid_waddr", 32'(ifc.ram_waddr), 32'd499);
        rst_n = 1'b0;
        #1;
        check("abort_we",   32'(ifc.ram_we),     32'd0);
        check("abort_re",   32'(ifc.ram_re),     32'd0);
        check("abort_busy", 32'(ifc.busy),       32'd0);
        check("abort_col",  32'(ifc.cursor_col), 32'd0);
        check("abort_row",  32'(ifc.cursor_row), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 32'(ifc.in_ready), 32'd1);
        send(8'h41, 8'h07, we1, ad, d, r1, bc);
        check("post_addr", 32'(ad), 32'd0);
        check("post_data", 32'(d),  32'h0741);
        check("post_col",  32'(ifc.cursor_col), 32'd1);

        check("bus_violations", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
